// File: rtl/stopwatch_core.sv
// stopwatch_core: prescaled tick plus mixed-radix BCD digit chain with run/stop, clear, lap freeze.
// Digits 3 and 5 count base 6 (tens of seconds / tens of minutes); every other digit counts base 10.
module stopwatch_core #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned NUM_DIGITS = 6,
    parameter bit          WRAP       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start_stop,
    input  logic                    i_clear,
    input  logic                    i_lap,
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic                    o_running,
    output logic                    o_lap_active,
    output logic                    o_cnt_done
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_STOPPED
    } state_t;

    state_t                  r_state;
    logic [PW-1:0]           r_presc;
    logic [4*NUM_DIGITS-1:0] r_count;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic                    r_running;
    logic                    r_lap;
    logic                    r_done;

    logic [4*NUM_DIGITS-1:0] w_count_inc;
    logic [4*NUM_DIGITS-1:0] w_count_tick;
    logic [4*NUM_DIGITS-1:0] w_count_nx;
    logic                    w_at_max;
    logic                    w_carry;
    logic                    w_tick;
    logic                    w_lap_nx;

    function automatic logic [3:0] digit_last(input int unsigned k);
        return (k == 3 || k == 5) ? 4'd5 : 4'd9;
    endfunction

    // Ripple the carry through all digits within one cycle.
    always_comb begin
        w_count_inc = r_count;
        w_at_max    = 1'b1;
        w_carry     = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (r_count[4*k +: 4] != digit_last(k)) begin
                w_at_max = 1'b0;
            end
            if (w_carry) begin
                if (r_count[4*k +: 4] == digit_last(k)) begin
                    w_count_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_tick       = (r_state == S_RUNNING) && !i_clear && !i_start_stop && (r_presc == PRESC_LAST);
        w_count_tick = w_at_max ? (WRAP ? '0 : r_count) : w_count_inc;
        w_count_nx   = i_clear ? '0 : (w_tick ? w_count_tick : r_count);
    end

    always_comb begin
        w_lap_nx = r_lap;
        if (i_clear) begin
            w_lap_nx = 1'b0;
        end else if (!i_start_stop && i_lap) begin
            if (r_state == S_RUNNING) begin
                w_lap_nx = ~r_lap;
            end else if (r_state == S_STOPPED) begin
                w_lap_nx = 1'b0;
            end
        end
    end

    // The display register doubles as the lap snapshot: it simply stops following the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_count   <= '0;
            r_disp    <= '0;
            r_running <= 1'b0;
            r_lap     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_count <= w_count_nx;
            r_lap   <= w_lap_nx;
            if (!w_lap_nx) begin
                r_disp <= w_count_nx;
            end
            if (i_clear) begin
                r_state   <= S_IDLE;
                r_presc   <= '0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                if (WRAP) begin
                    r_done <= 1'b0;
                end
                case (r_state)
                    S_IDLE: begin
                        if (i_start_stop) begin
                            r_state   <= S_RUNNING;
                            r_running <= 1'b1;
                            r_presc   <= '0;
                        end
                    end
                    S_RUNNING: begin
                        if (i_start_stop) begin
                            r_state   <= S_STOPPED;
                            r_running <= 1'b0;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            if (w_at_max) begin
                                r_done <= 1'b1;
                                if (!WRAP) begin
                                    r_state   <= S_STOPPED;
                                    r_running <= 1'b0;
                                end
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    S_STOPPED: begin
                        if (i_start_stop && !r_done) begin
                            r_state   <= S_RUNNING;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_digits     = r_disp;
    assign o_running    = r_running;
    assign o_lap_active = r_lap;
    assign o_cnt_done   = r_done;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: four stopwatch_core configurations driven by shared pulses,
// checked against an integer-count behavioural model and directed constants.
`timescale 1ns/1ps
module tb_stopwatch_core;

    logic clk          = 1'b0;
    logic rst_n        = 1'b0;
    logic i_start_stop = 1'b0;
    logic i_clear      = 1'b0;
    logic i_lap        = 1'b0;

    always #5 clk = ~clk;

    logic [23:0] w_dig_a, w_dig_d;
    logic [7:0]  w_dig_b, w_dig_c;
    logic        w_run_a, w_run_b, w_run_c, w_run_d;
    logic        w_lap_a, w_lap_b, w_lap_c, w_lap_d;
    logic        w_done_a, w_done_b, w_done_c, w_done_d;

    logic [23:0] dig  [4];
    logic        run  [4];
    logic        lapo [4];
    logic        done [4];

    always_comb begin
        dig[0] = w_dig_a;            dig[1] = {16'h0, w_dig_b};
        dig[2] = {16'h0, w_dig_c};   dig[3] = w_dig_d;
        run[0] = w_run_a;  run[1] = w_run_b;  run[2] = w_run_c;  run[3] = w_run_d;
        lapo[0] = w_lap_a; lapo[1] = w_lap_b; lapo[2] = w_lap_c; lapo[3] = w_lap_d;
        done[0] = w_done_a; done[1] = w_done_b; done[2] = w_done_c; done[3] = w_done_d;
    end

    stopwatch_core #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(6), .WRAP(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .i_start_stop(i_start_stop), .i_clear(i_clear), .i_lap(i_lap),
        .o_digits(w_dig_a), .o_running(w_run_a), .o_lap_active(w_lap_a), .o_cnt_done(w_done_a));
    stopwatch_core #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(2), .WRAP(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .i_start_stop(i_start_stop), .i_clear(i_clear), .i_lap(i_lap),
        .o_digits(w_dig_b), .o_running(w_run_b), .o_lap_active(w_lap_b), .o_cnt_done(w_done_b));
    stopwatch_core #(.CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(2), .WRAP(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .i_start_stop(i_start_stop), .i_clear(i_clear), .i_lap(i_lap),
        .o_digits(w_dig_c), .o_running(w_run_c), .o_lap_active(w_lap_c), .o_cnt_done(w_done_c));
    stopwatch_core #(.CLK_HZ(2), .TICK_HZ(1), .NUM_DIGITS(6), .WRAP(1'b1)) u_d (
        .clk(clk), .rst_n(rst_n), .i_start_stop(i_start_stop), .i_clear(i_clear), .i_lap(i_lap),
        .o_digits(w_dig_d), .o_running(w_run_d), .o_lap_active(w_lap_d), .o_cnt_done(w_done_d));

    typedef struct {
        int value;
        int phase;
        bit started;
        bit running;
        bit lap;
        int snap;
        bit done;
    } model_t;

    model_t mdl [4];
    int     cfg_div  [4] = '{10, 10, 10, 2};
    int     cfg_nd   [4] = '{6, 2, 2, 6};
    bit     cfg_wrap [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int     n_checks = 0;
    int     n_pass   = 0;

    function automatic int radix_of(input int k);
        return (k == 3 || k == 5) ? 6 : 10;
    endfunction

    function automatic int max_value(input int nd);
        int p = 1;
        for (int k = 0; k < nd; k++) p = p * radix_of(k);
        return p - 1;
    endfunction

    function automatic logic [23:0] to_bcd(input int v, input int nd);
        logic [23:0] r = '0;
        int          rem = v;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(rem % radix_of(k));
            rem = rem / radix_of(k);
        end
        return r;
    endfunction

    // Elapsed time kept as a plain integer; the display is derived from it by radix division.
    function automatic model_t model_next(input model_t m, input bit st, input bit cl, input bit lp,
                                          input int div, input int maxv, input bit wrap);
        model_t n = m;
        if (cl) begin
            n = '{default: 0};
            return n;
        end
        if (wrap) n.done = 1'b0;
        if (!m.started) begin
            if (st) begin
                n.started = 1'b1;
                n.running = 1'b1;
                n.phase   = 0;
            end
        end else if (m.running) begin
            if (st) begin
                n.running = 1'b0;
            end else begin
                if (lp) begin
                    n.lap = !m.lap;
                    if (!m.lap) n.snap = m.value;
                end
                if (m.phase == div - 1) begin
                    n.phase = 0;
                    if (m.value == maxv) begin
                        n.done = 1'b1;
                        if (wrap) n.value = 0;
                        else      n.running = 1'b0;
                    end else begin
                        n.value = m.value + 1;
                    end
                end else begin
                    n.phase = m.phase + 1;
                end
            end
        end else begin
            if (st) begin
                if (!(m.done && !wrap)) n.running = 1'b1;
            end else if (lp) begin
                n.lap = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic step(input bit st, input bit cl, input bit lp);
        i_start_stop = st;
        i_clear      = cl;
        i_lap        = lp;
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            mdl[i] = model_next(mdl[i], st, cl, lp, cfg_div[i], max_value(cfg_nd[i]), cfg_wrap[i]);
        @(negedge clk);
        i_start_stop = 1'b0;
        i_clear      = 1'b0;
        i_lap        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        i_start_stop = 1'b0;
        i_clear      = 1'b0;
        i_lap        = 1'b0;
        rst_n        = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = '{default: 0};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        idle(100);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({dig[i], run[i], lapo[i], done[i]} !== 27'h0)
                $display("FAIL reset_idle[%0d]: got dig=%h run=%b lap=%b done=%b want all zero",
                         i, dig[i], run[i], lapo[i], done[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        idle(25);
        n_checks++;
        if (dig[0] !== 24'h000002) $display("FAIL pre_reset_count: got %h want %h", dig[0], 24'h000002);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dig[0], run[0]} !== 25'h0) $display("FAIL async_reset: got dig=%h run=%b want 0", dig[0], run[0]);
        else n_pass++;
        @(negedge clk);
        for (int i = 0; i < 4; i++) mdl[i] = '{default: 0};
        rst_n = 1'b1;
        idle(15);
        n_checks++;
        if ({dig[0], run[0], done[0]} !== 26'h0)
            $display("FAIL after_reset_release: got dig=%h run=%b done=%b want 0", dig[0], run[0], done[0]);
        else n_pass++;
    endtask

    task automatic test_run_stop;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (run[0] !== 1'b1) $display("FAIL start_running: got %b want 1", run[0]);
        else n_pass++;
        idle(9);
        n_checks++;
        if (dig[0] !== 24'h000000) $display("FAIL before_first_tick: got %h want %h", dig[0], 24'h0);
        else n_pass++;
        idle(1);
        n_checks++;
        if (dig[0] !== 24'h000001) $display("FAIL first_tick: got %h want %h", dig[0], 24'h000001);
        else n_pass++;
        idle(90);
        n_checks++;
        if (dig[0] !== 24'h000010) $display("FAIL ten_ticks: got %h want %h", dig[0], 24'h000010);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        idle(50);
        n_checks++;
        if ({dig[0], run[0]} !== {24'h000010, 1'b0})
            $display("FAIL stopped_hold: got dig=%h run=%b want 000010 run=0", dig[0], run[0]);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        idle(9);
        n_checks++;
        if ({dig[0], run[0]} !== {24'h000010, 1'b1})
            $display("FAIL resume_wait: got dig=%h run=%b want 000010 run=1", dig[0], run[0]);
        else n_pass++;
        idle(1);
        n_checks++;
        if (dig[0] !== 24'h000011) $display("FAIL resume_tick: got %h want %h", dig[0], 24'h000011);
        else n_pass++;
    endtask

    task automatic test_carry;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        idle(198);
        n_checks++;
        if (dig[3] !== 24'h000099) $display("FAIL carry_at_99: got %h want %h", dig[3], 24'h000099);
        else n_pass++;
        idle(2);
        n_checks++;
        if (dig[3] !== 24'h000100) $display("FAIL carry_to_100: got %h want %h", dig[3], 24'h000100);
        else n_pass++;
        idle(11798);
        n_checks++;
        if (dig[3] !== 24'h005999) $display("FAIL carry_at_5999: got %h want %h", dig[3], 24'h005999);
        else n_pass++;
        idle(2);
        n_checks++;
        if (dig[3] !== 24'h010000) $display("FAIL base6_carry: got %h want %h", dig[3], 24'h010000);
        else n_pass++;
    endtask

    task automatic test_wrap_saturate;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        idle(999);
        n_checks++;
        if ({dig[1], done[1], dig[2], done[2]} !== {24'h99, 1'b0, 24'h99, 1'b0})
            $display("FAIL at_max: got b=%h/%b c=%h/%b want 99/0 99/0", dig[1], done[1], dig[2], done[2]);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({dig[1], done[1], run[1]} !== {24'h00, 1'b1, 1'b1})
            $display("FAIL wrap_tick: got dig=%h done=%b run=%b want 00 1 1", dig[1], done[1], run[1]);
        else n_pass++;
        n_checks++;
        if ({dig[2], done[2], run[2]} !== {24'h99, 1'b1, 1'b0})
            $display("FAIL saturate_tick: got dig=%h done=%b run=%b want 99 1 0", dig[2], done[2], run[2]);
        else n_pass++;
        idle(1);
        n_checks++;
        if ({done[1], run[1], done[2]} !== 3'b011)
            $display("FAIL done_width: got b_done=%b b_run=%b c_done=%b want 0 1 1", done[1], run[1], done[2]);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({dig[2], done[2], run[2]} !== {24'h99, 1'b1, 1'b0})
            $display("FAIL saturate_start_ignored: got dig=%h done=%b run=%b want 99 1 0", dig[2], done[2], run[2]);
        else n_pass++;
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({dig[2], done[2], run[2]} !== 26'h0)
            $display("FAIL saturate_clear: got dig=%h done=%b run=%b want 00 0 0", dig[2], done[2], run[2]);
        else n_pass++;
    endtask

    task automatic test_lap;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        idle(35);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({dig[0], lapo[0]} !== {24'h000003, 1'b1})
            $display("FAIL lap_on: got dig=%h lap=%b want 000003 1", dig[0], lapo[0]);
        else n_pass++;
        idle(50);
        n_checks++;
        if ({dig[0], lapo[0]} !== {24'h000003, 1'b1})
            $display("FAIL lap_frozen: got dig=%h lap=%b want 000003 1", dig[0], lapo[0]);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({dig[0], lapo[0]} !== {24'h000008, 1'b0})
            $display("FAIL lap_off: got dig=%h lap=%b want 000008 0", dig[0], lapo[0]);
        else n_pass++;
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({dig[0], run[0], lapo[0]} !== 26'h0)
            $display("FAIL clear_beats_start: got dig=%h run=%b lap=%b want 0", dig[0], run[0], lapo[0]);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (lapo[0] !== 1'b0) $display("FAIL lap_in_idle: got %b want 0", lapo[0]);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 1'b1);
        idle(10);
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({dig[0], lapo[0], run[0]} !== {24'h000000, 1'b1, 1'b0})
            $display("FAIL stop_keeps_lap: got dig=%h lap=%b run=%b want 000000 1 0", dig[0], lapo[0], run[0]);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({dig[0], lapo[0]} !== {24'h000001, 1'b0})
            $display("FAIL lap_in_stopped: got dig=%h lap=%b want 000001 0", dig[0], lapo[0]);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [26:0] exp_v;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 11) == 0);
            for (int i = 0; i < 4; i++) begin
                exp_v = {to_bcd(mdl[i].lap ? mdl[i].snap : mdl[i].value, cfg_nd[i]),
                         mdl[i].running, mdl[i].lap, mdl[i].done};
                n_checks++;
                if ({dig[i], run[i], lapo[i], done[i]} !== exp_v)
                    $display("FAIL random[%0d] cycle %0d: got dig=%h run=%b lap=%b done=%b want dig=%h run=%b lap=%b done=%b",
                             i, c, dig[i], run[i], lapo[i], done[i],
                             exp_v[26:3], exp_v[2], exp_v[1], exp_v[0]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_reset_mid();
        test_run_stop();
        test_carry();
        test_wrap_saturate();
        test_lap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
